apb3_m_arb_ctrl: RTL

//  Multi-requester APB3 master controller. Round-robin arbitrates NUM_REQ

---
 rtl/apb3_m_pkg.sv | 9 +
 rtl/apb3_m_arb_ctrl_if.sv | 28 ++
 rtl/apb3_rr_arbiter.sv | 29 ++
 rtl/apb3_m_arb_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/apb3_m_pkg.sv
// Shared types and default widths for the multi-requester APB3 master.
package apb3_m_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} apb_m_state_e;
  localparam int APB_PROT_W      = 3;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 256;
endpackage

// File: rtl/apb3_m_arb_ctrl_if.sv
// APB3 bus bundle between the arbitrating master and its slave.
interface apb3_m_arb_ctrl_if
  import apb3_m_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [STRB_W-1:0]     PSTRB;
  logic [APB_PROT_W-1:0] PPROT;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_rr_arbiter.sv
// Combinational round-robin pick: first valid at or above ptr, wrapping.
module apb3_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  localparam logic [IW:0] NW = N[IW:0];

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    // rotating the doubled vector puts ptr at bit 0, so the lowest set bit is the winner
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = IW'(i);
    sum     = {1'b0, ptr} + {1'b0, off};
    gnt_idx = (sum >= NW) ? IW'(sum - NW) : sum[IW-1:0];
    any     = |req;
    gnt     = any ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/apb3_m_arb_ctrl.sv
// Round-robin multi-requester APB3 master: grant, SETUP/ACCESS sequencing,
// wait-state and timeout handling, one-hot completion back to the requester.
module apb3_m_arb_ctrl
  import apb3_m_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STRB_W      = DATA_W / 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]     req_strb,
  input  logic [NUM_REQ*APB_PROT_W-1:0] req_prot,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_slverr,
  output logic                          rsp_timeout,
  apb3_m_arb_ctrl_if.master             apb
);
  localparam int IW    = $clog2(NUM_REQ);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [STRB_W-1:0]     strb;
    logic [APB_PROT_W-1:0] prot;
  } req_t;

  apb_m_state_e       state, state_nxt;
  logic [IW-1:0]      rr_ptr, gnt_idx, cur_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_any, grant, done, tmo_hit;
  logic [TMO_W-1:0]   tmo_cnt;
  req_t               sel;

  apb3_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    sel.write = req_write[gnt_idx];
    sel.addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel.wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    sel.strb  = req_strb[int'(gnt_idx)*STRB_W +: STRB_W];
    sel.prot  = req_prot[int'(gnt_idx)*APB_PROT_W +: APB_PROT_W];
  end

  // PREADY on the final count wins, so the abort needs PREADY low
  assign tmo_hit = (TIMEOUT_CYC != 0) && (state == ACCESS) && !apb.PREADY &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (gnt_any) begin
                 req_ready = gnt_oh;
                 grant     = 1'b1;
                 state_nxt = SETUP;
               end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (apb.PREADY || tmo_hit) begin
                 done      = 1'b1;
                 state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rr_ptr      <= '0;
      cur_idx     <= '0;
      tmo_cnt     <= '0;
      apb.PSELx   <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      apb.PSTRB   <= '0;
      apb.PPROT   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (grant) begin
        rr_ptr      <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cur_idx     <= gnt_idx;
        apb.PSELx   <= 1'b1;
        apb.PWRITE  <= sel.write;
        apb.PADDR   <= sel.addr;
        apb.PWDATA  <= sel.write ? sel.wdata : '0;
        apb.PSTRB   <= sel.write ? sel.strb : '0;
        apb.PPROT   <= sel.prot;
      end
      if (state == SETUP) apb.PENABLE <= 1'b1;
      if (state == ACCESS)
        tmo_cnt <= (done || TIMEOUT_CYC == 0) ? '0 : tmo_cnt + 1'b1;
      if (done) begin
        apb.PSELx   <= 1'b0;
        apb.PENABLE <= 1'b0;
        rsp_valid   <= NUM_REQ'(1) << cur_idx;
        rsp_rdata   <= (tmo_hit || apb.PWRITE) ? '0 : apb.PRDATA;
        rsp_slverr  <= tmo_hit | apb.PSLVERR;
        rsp_timeout <= tmo_hit;
      end
    end
  end
endmodule
